// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle arithmetic/logic ops plus iterative MUL/DIVU/REMU.
// Result and CMP flags are registered and held until the consumer takes them.
module alu_mc #(
  parameter int WIDTH      = 16,
  parameter bit MUL_DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_CMP  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_LSH  = 4'b0110;
  localparam logic [3:0] OP_LUI  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  localparam int                CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]     LAST      = CW'(WIDTH - 1);
  localparam logic [WIDTH:0]    SHIFT_LIM = (WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept, multi_op, last_step;
  logic [3:0]        op_code;
  logic [WIDTH-1:0]  opnd, shreg, acc;
  logic [CW-1:0]     count;

  logic [WIDTH-1:0]  alu_res, sub_res, shl_res;
  logic [WIDTH:0]    shamt;
  logic [4:0]        cmp_flags;
  logic [WIDTH-1:0]  mul_acc, rem_nxt, quo_nxt, acc_nxt, shreg_nxt, fin_res;
  logic [WIDTH:0]    rem_sh, rem_diff;
  logic              div_ge;

  assign accept    = in_valid && in_ready;
  assign multi_op  = MUL_DIV_EN && (alucode inside {OP_MUL, OP_DIVU, OP_REMU});
  assign last_step = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: each combinational block assigns a default first so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = multi_op ? BUSY : DONE;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = multi_op ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  // Single-cycle ops; the shift count is a signed magnitude, widened so -2^(W-1) negates cleanly.
  always_comb begin
    sub_res   = b - a;
    shamt     = a[WIDTH-1] ? ({1'b0, ~a} + (WIDTH + 1)'(1)) : {1'b0, a};
    shl_res   = '0;
    if (shamt < SHIFT_LIM) shl_res = a[WIDTH-1] ? (b >> shamt) : (b << shamt);
    cmp_flags = {b < a, b < a,
                 (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != b[WIDTH-1]),
                 a == b, $signed(b) < $signed(a)};
    case (alucode)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = sub_res;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_LSH:  alu_res = shl_res;
      OP_LUI:  alu_res = {a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
      default: alu_res = a;
    endcase
  end

  // One iteration per BUSY cycle: opnd holds a, shreg streams b out MSB-first.
  // MUL accumulates MSB-first; DIV restores, with the quotient shifted into shreg.
  always_comb begin
    mul_acc  = (acc << 1) + (shreg[WIDTH-1] ? opnd : '0);
    rem_sh   = {acc, shreg[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    div_ge   = !rem_diff[WIDTH];
    rem_nxt  = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt  = {shreg[WIDTH-2:0], div_ge};
    if (op_code == OP_MUL) begin
      acc_nxt   = mul_acc;
      shreg_nxt = shreg << 1;
    end else begin
      acc_nxt   = rem_nxt;
      shreg_nxt = quo_nxt;
    end
    case (op_code)
      OP_DIVU: fin_res = quo_nxt;
      OP_REMU: fin_res = rem_nxt;
      default: fin_res = mul_acc;
    endcase
  end

  // NOTE: the whole datapath is reset, so a reset mid-BUSY also clears the counter and partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      flags   <= '0;
      op_code <= '0;
      opnd    <= '0;
      shreg   <= '0;
      acc     <= '0;
      count   <= '0;
    end else if (accept) begin
      op_code <= alucode;
      opnd    <= a;
      shreg   <= b;
      acc     <= '0;
      count   <= '0;
      if (!multi_op)         result <= alu_res;
      if (alucode == OP_CMP) flags  <= cmp_flags;
    end else if (busy) begin
      acc   <= acc_nxt;
      shreg <= shreg_nxt;
      count <= count + CW'(1);
      if (last_step) result <= fin_res;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a vector table for every opcode, then hand-built
// sequences for BUSY-time requests, output backpressure and reset mid-divide.
module tb_alu_mc;
  localparam int W = 16;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, CMP = 4'b0010, AND_ = 4'b0011,
                         OR_ = 4'b0100, XOR_ = 4'b0101, LSH = 4'b0110, LUI = 4'b0111,
                         MUL = 4'b1010, DIVU = 4'b1011, REMU = 4'b1100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   alucode = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int n_pass  = 0;
  int n_total = 0;

  alu_mc #(.WIDTH(W), .MUL_DIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alucode(alucode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   fl;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one request with out_ready high and wait (bounded) for its result.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] res, output logic [4:0] fl, output int lat);
    in_valid = 1'b1; alucode = c; a = av; b = bv; out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 100);
    res = result;
    fl  = flags;
  endtask

  initial begin
    logic [W-1:0] r;
    logic [4:0]   f;
    int           lat, cycles, busy_cnt, bad;

    vecs.push_back('{ADD,  16'h0003, 16'hFFFF, 16'h0002, 5'b00000, 1});
    vecs.push_back('{SUB,  16'h0005, 16'h0003, 16'hFFFE, 5'b00000, 1});
    vecs.push_back('{CMP,  16'h0001, 16'h8000, 16'h0001, 5'b00101, 1});
    vecs.push_back('{XOR_, 16'hF0F0, 16'hFF00, 16'h0FF0, 5'b00101, 1});
    vecs.push_back('{AND_, 16'hF0F0, 16'hFF00, 16'hF000, 5'b00101, 1});
    vecs.push_back('{OR_,  16'hF0F0, 16'hFF00, 16'hFFF0, 5'b00101, 1});
    vecs.push_back('{LSH,  16'h0004, 16'h1234, 16'h2340, 5'b00101, 1});
    vecs.push_back('{LSH,  16'hFFFC, 16'h1234, 16'h0123, 5'b00101, 1});
    vecs.push_back('{LSH,  16'h0010, 16'hFFFF, 16'h0000, 5'b00101, 1});
    vecs.push_back('{LSH,  16'hFFF0, 16'hFFFF, 16'h0000, 5'b00101, 1});
    vecs.push_back('{LSH,  16'h8000, 16'hFFFF, 16'h0000, 5'b00101, 1});
    vecs.push_back('{LSH,  16'h000F, 16'h0001, 16'h8000, 5'b00101, 1});
    vecs.push_back('{LSH,  16'hFFF1, 16'h8000, 16'h0001, 5'b00101, 1});
    vecs.push_back('{LUI,  16'h12AB, 16'h34CD, 16'hABCD, 5'b00101, 1});
    vecs.push_back('{CMP,  16'h0005, 16'h0005, 16'h0005, 5'b00010, 1});
    vecs.push_back('{CMP,  16'h0005, 16'h0003, 16'h0005, 5'b11001, 1});
    vecs.push_back('{CMP,  16'h8000, 16'h0001, 16'h8000, 5'b11100, 1});
    vecs.push_back('{4'b1000, 16'hBEEF, 16'h0001, 16'hBEEF, 5'b11100, 1});
    vecs.push_back('{4'b1111, 16'h1357, 16'h0002, 16'h1357, 5'b11100, 1});
    vecs.push_back('{MUL,  16'h0013, 16'h0021, 16'h0273, 5'b11100, 17});
    vecs.push_back('{MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 5'b11100, 17});
    vecs.push_back('{MUL,  16'h0100, 16'h0300, 16'h0000, 5'b11100, 17});
    vecs.push_back('{DIVU, 16'h0000, 16'h1234, 16'hFFFF, 5'b11100, 17});
    vecs.push_back('{REMU, 16'h0000, 16'h1234, 16'h1234, 5'b11100, 17});
    vecs.push_back('{DIVU, 16'h0007, 16'h0064, 16'h000E, 5'b11100, 17});
    vecs.push_back('{REMU, 16'h0007, 16'h0064, 16'h0002, 5'b11100, 17});
    vecs.push_back('{DIVU, 16'h0003, 16'hFFFF, 16'h5555, 5'b11100, 17});
    vecs.push_back('{REMU, 16'h0003, 16'hFFFF, 16'h0000, 5'b11100, 17});
    vecs.push_back('{DIVU, 16'hFFFF, 16'h0005, 16'h0000, 5'b11100, 17});
    vecs.push_back('{REMU, 16'hFFFF, 16'h0005, 16'h0005, 5'b11100, 17});

    // Reset state
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].code, vecs[i].a, vecs[i].b, r, f, lat);
      check($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_res", i),   32'(r),   32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 32'(f),   32'(vecs[i].fl));
    end

    // MUL with requests pulsed during BUSY (back-to-back from DONE)
    in_valid = 1'b1; alucode = MUL; a = 16'h0013; b = 16'h0021;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 1; busy_cnt = 0; bad = 0;
    while (!out_valid && cycles < 60) begin
      if (busy) busy_cnt++;
      if (in_ready) bad++;
      in_valid = (busy_cnt >= 3 && busy_cnt <= 6);
      alucode = ADD; a = 16'h0001; b = 16'h0001;
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    check("mul_busy_lat",    32'(cycles),   32'd17);
    check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
    check("mul_ready_low",   32'(bad),      32'd0);
    check("mul_result",      32'(result),   32'h0273);
    check("mul_flags",       32'(flags),    32'b11100);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    check("mul_no_dup", 32'(bad), 32'd0);

    // Backpressure: result held, then back-to-back accept on release
    out_ready = 1'b0;
    in_valid = 1'b1; alucode = ADD; a = 16'h0010; b = 16'h0020;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_valid",  32'(out_valid), 32'd1);
    check("hold_result", 32'(result),    32'h0030);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      a = W'($urandom); b = W'($urandom); alucode = CMP;
      @(posedge clk); #1;
      if (result !== 16'h0030 || in_ready !== 1'b0 || out_valid !== 1'b1 || flags !== 5'b11100) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);
    in_valid = 1'b1; alucode = SUB; a = 16'h0001; b = 16'h000A; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid",  32'(out_valid), 32'd1);
    check("b2b_result", 32'(result),    32'h0009);

    // Reset at BUSY cycle 8 of a DIVU
    in_valid = 1'b1; alucode = DIVU; a = 16'h0003; b = 16'h0064;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(busy),      32'd0);
    check("mid_rst_valid",  32'(out_valid), 32'd0);
    check("mid_rst_flags",  32'(flags),     32'd0);
    check("mid_rst_result", 32'(result),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'd0);
    do_op(DIVU, 16'h0003, 16'h0064, r, f, lat);
    check("post_rst_div_lat",   32'(lat), 32'd17);
    check("post_rst_div_res",   32'(r),   32'h0021);
    check("post_rst_div_flags", 32'(f),   32'd0);
    do_op(REMU, 16'h0003, 16'h0064, r, f, lat);
    check("post_rst_rem_res", 32'(r), 32'h0001);
    do_op(ADD, 16'h0001, 16'h0002, r, f, lat);
    check("post_rst_add_lat", 32'(lat), 32'd1);
    check("post_rst_add_res", 32'(r),   32'h0003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; even, >= 8.
REQ-002 Parameter MUL_DIV_EN, default 1: 1 enables the multi-cycle MUL/DIVU/REMU ops; 0 makes those codes behave as default (result = a).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 alucode  input  4  operation select.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 flags  output  5  registered PSR bits {C,L,F,Z,N} = [4:0].
REQ-013 busy  output  1  high while in state BUSY.

Function
REQ-014 Request accepted on a cycle with in_valid && in_ready; a, b, alucode captured on that edge.
REQ-015 States: IDLE, BUSY, DONE; in_ready = (IDLE) || (DONE && out_ready); out_valid = (DONE).
REQ-016 Single-cycle op accepted -> DONE next edge with result loaded (latency 1).
REQ-017 Multi-cycle op accepted -> BUSY for exactly WIDTH cycles (iteration counter), then DONE (out_valid asserted WIDTH+1 edges after acceptance).
REQ-018 DONE && out_ready && !in_valid -> IDLE; DONE && out_ready && in_valid -> accepts new request (back-to-back, no bubble).
REQ-019 DONE && !out_ready: result and flags held stable; in_ready low.
REQ-020 in_valid in BUSY ignored (in_ready low); no request lost or duplicated.
REQ-021 0000 ADD: a+b mod 2^WIDTH; 0001 SUB: b-a mod 2^WIDTH.
REQ-022 0010 CMP: result = a; flags updated: N = signed(b)<signed(a), Z = (a==b), F = signed overflow of b-a, L = unsigned b<a, C = borrow of b-a.
REQ-023 0011 AND, 0100 OR, 0101 XOR: bitwise.
REQ-024 0110 LSH: a signed shift count; a>=0 -> b<<a, a<0 -> b>>(-a) logical; |count| >= WIDTH -> 0.
REQ-025 0111 LUI: {a[WIDTH/2-1:0], b[WIDTH/2-1:0]}.
REQ-026 1010 MUL: low WIDTH bits of unsigned b*a, shift-add, one bit per BUSY cycle.
REQ-027 1011 DIVU / 1100 REMU: restoring unsigned divide b/a, one quotient bit per BUSY cycle; quotient or remainder returned.
REQ-028 Divide by zero (a==0): still WIDTH cycles; DIVU -> all ones, REMU -> b.
REQ-029 All other codes: result = a, single-cycle.
REQ-030 Only CMP writes flags; every other op leaves flags unchanged (flags persist across ops).

Reset
REQ-031 rst_n low at any time, including mid-BUSY: state IDLE, result 0, flags 0, out_valid 0, busy 0, counter 0; in-flight op discarded.
REQ-032 in_ready high the first cycle after rst_n deasserts.

Verification
REQ-033 ADD a=0x0003 b=0xFFFF, out_ready=1 -> out_valid 1 cycle later, result 0x0002, flags unchanged (0).
REQ-034 CMP a=0x0001 b=0x8000 -> result 0x0001, flags N=1 Z=0 F=1 L=0 C=0 (5'b00101); following XOR leaves flags 5'b00101.
REQ-035 MUL a=0x0013 b=0x0021 -> busy 16 cycles, out_valid at cycle 17, result 0x0273; in_valid pulses during BUSY ignored.
REQ-036 DIVU a=0 b=0x1234 -> result 0xFFFF after 17 cycles; REMU same operands -> 0x1234.
REQ-037 Result held with out_ready=0 for 5 cycles -> result stable, in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted same cycle.
REQ-038 rst_n pulsed low at BUSY cycle 8 of DIVU -> out_valid never asserts for it, flags 0, next request completes normally.
